sync_fifo: RTL and testbench

- Single-clock, synchronous-write FIFO: 16 entries x 8 bits.
- First-word-fall-through read: the head entry is always visible on rdata.
- General-purpose buffer between a producer (wen/wdata) and a consumer (ren/rdata) in the same clock domain.
- Internally split into a write-pointer unit, a read-pointer unit, a shared storage array and an occupancy counter.

---
 rtl/sync_fifo_if.sv | 24 ++
 rtl/sync_fifo.sv | 82 ++++++++
 tb/tb_sync_fifo.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo.
// master: the side driving writes/reads; slave: the FIFO itself.
interface sync_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              wen;
  logic [DATA_W-1:0] wdata;
  logic              ren;
  logic [DATA_W-1:0] rdata;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;

  modport master (
    output wen, wdata, ren,
    input  rdata, empty, full, count
  );

  modport slave (
    input  wen, wdata, ren,
    output rdata, empty, full, count
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO, 2**ADDR_W entries of DATA_W bits, first-word-fall-through:
// the head entry is always presented on rdata. Built from a write-pointer
// unit, a read-pointer unit, a shared storage array and an occupancy counter.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  sync_fifo_if.slave   bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   count_q;
  logic              empty_w;
  logic              full_w;
  logic              do_wr;
  logic              do_rd;

  // Status flags derive from the registered occupancy only.
  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CNT_FULL);

  // Accept qualifiers: a write into a full FIFO or a read from an empty one
  // is dropped regardless of what the other side does in the same cycle.
  assign do_wr = bus.wen & ~full_w;
  assign do_rd = bus.ren & ~empty_w;

  // Write-pointer unit: advances modulo depth on every accepted write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
    end else if (do_wr) begin
      wptr <= wptr + PTR_ONE;
    end
  end

  // Read-pointer unit: advances modulo depth on every accepted read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr <= '0;
    end else if (do_rd) begin
      rptr <= rptr + PTR_ONE;
    end
  end

  // Storage array: contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wptr] <= bus.wdata;
    end
  end

  // Occupancy counter: simultaneous accepted read and write cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      unique case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head of queue falls through combinationally; no write-to-read bypass,
  // so a word written into an empty FIFO appears only after the edge.
  assign bus.rdata = mem[rptr];
  assign bus.empty = empty_w;
  assign bus.full  = full_w;
  assign bus.count = count_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed, table-driven bench for sync_fifo (16 x 8, FWFT).
module tb_sync_fifo;

  logic clk;
  logic rst;

  sync_fifo_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  sync_fifo #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wen;
    logic [7:0] wdata;
    logic       ren;
    logic [4:0] exp_count;
    logic       chk_head;
    logic [7:0] exp_head;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic w, input logic [7:0] d, input logic r,
                     input logic [4:0] c, input logic chk, input logic [7:0] h);
    vec_t v;
    v.wen = w; v.wdata = d; v.ren = r;
    v.exp_count = c; v.chk_head = chk; v.exp_head = h;
    vecs.push_back(v);
  endtask

  task automatic check_status(input string tag, input int exp_count);
    check({tag, " count"}, int'(bus.count), exp_count);
    check({tag, " empty"}, int'(bus.empty), int'(exp_count == 0));
    check({tag, " full"},  int'(bus.full),  int'(exp_count == 16));
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the edge.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r);
    bus.wen = w; bus.wdata = d; bus.ren = r;
    @(posedge clk);
    #1;
    bus.wen = 1'b0; bus.ren = 1'b0;
  endtask

  // Reference occupancy model and flag invariants, checked every cycle.
  int   model_count = 0;
  logic model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      model_count = int'(bus.count)
                  + int'(bus.wen & ~bus.full) - int'(bus.ren & ~bus.empty);
      model_valid = 1'b1;
    end else begin
      model_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    check("inv empty_and_full", int'(bus.empty & bus.full), 0);
    check("inv count_max", int'(bus.count <= 5'd16), 1);
    if (model_valid && rst)
      check("inv count_delta", int'(bus.count), model_count);
    if (!rst) model_valid = 1'b0;
  end

  always @(negedge rst) model_valid = 1'b0;

  initial begin
    // ---- vector table ----
    // single write / read
    add(1, 8'h01, 0, 5'd1, 1, 8'h01);
    add(0, 8'h00, 1, 5'd0, 0, 8'h00);
    // fill with 0x00..0x0F, head stays 0x00
    for (int i = 0; i < 16; i++) add(1, 8'(i), 0, 5'(i + 1), 1, 8'h00);
    // overflow write dropped
    add(1, 8'hFF, 0, 5'd16, 1, 8'h00);
    // drain: after pop j the head is j+1
    for (int j = 0; j < 15; j++) add(0, 8'h00, 1, 5'(15 - j), 1, 8'(j + 1));
    add(0, 8'h00, 1, 5'd0, 0, 8'h00);
    // empty + wen/ren: only the write happens
    add(1, 8'h33, 1, 5'd1, 1, 8'h33);
    add(0, 8'h00, 1, 5'd0, 0, 8'h00);
    // wrap-around: 10 in/out, then 0xA0..0xA9 across the pointer wrap
    for (int i = 0; i < 10; i++) add(1, 8'(8'h50 + i), 0, 5'(i + 1), 1, 8'h50);
    for (int i = 0; i < 9; i++)  add(0, 8'h00, 1, 5'(9 - i), 1, 8'(8'h51 + i));
    add(0, 8'h00, 1, 5'd0, 0, 8'h00);
    for (int i = 0; i < 10; i++) add(1, 8'(8'hA0 + i), 0, 5'(i + 1), 1, 8'hA0);
    for (int i = 0; i < 9; i++)  add(0, 8'h00, 1, 5'(9 - i), 1, 8'(8'hA1 + i));
    add(0, 8'h00, 1, 5'd0, 0, 8'h00);
    // full + wen/ren: oldest popped, 0xEE dropped
    for (int i = 0; i < 16; i++) add(1, 8'(8'hC0 + i), 0, 5'(i + 1), 1, 8'hC0);
    add(1, 8'hEE, 1, 5'd15, 1, 8'hC1);
    for (int j = 0; j < 14; j++) add(0, 8'h00, 1, 5'(14 - j), 1, 8'(8'hC2 + j));
    add(0, 8'h00, 1, 5'd0, 0, 8'h00);
    // count=5 + wen/ren: count holds, order preserved
    for (int i = 0; i < 5; i++) add(1, 8'(8'h70 + i), 0, 5'(i + 1), 1, 8'h70);
    add(1, 8'h75, 1, 5'd5, 1, 8'h71);
    for (int j = 0; j < 4; j++) add(0, 8'h00, 1, 5'(4 - j), 1, 8'(8'h72 + j));
    add(0, 8'h00, 1, 5'd0, 0, 8'h00);

    // ---- reset then idle ----
    rst = 1'b0;
    bus.wen = 1'b0; bus.ren = 1'b0; bus.wdata = 8'h00;
    #2;
    check_status("reset", 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle(0, 8'h00, 0);
      check_status($sformatf("idle%0d", k), 0);
    end

    // ---- table ----
    foreach (vecs[i]) begin
      cycle(vecs[i].wen, vecs[i].wdata, vecs[i].ren);
      check_status($sformatf("vec%0d", i), int'(vecs[i].exp_count));
      if (vecs[i].chk_head)
        check($sformatf("vec%0d rdata", i), int'(bus.rdata), int'(vecs[i].exp_head));
    end

    // ---- async reset mid-stream ----
    for (int i = 0; i < 7; i++) cycle(1, 8'(8'h90 + i), 0);
    check_status("pre_reset", 7);
    #3;
    rst = 1'b0;
    #1;
    check_status("async_reset", 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle(0, 8'h00, 0);
    check_status("post_reset_idle", 0);
    cycle(1, 8'h02, 0);
    check_status("post_reset_wr", 1);
    check("post_reset rdata", int'(bus.rdata), 32'h02);
    cycle(0, 8'h00, 1);
    check_status("post_reset_rd", 0);

    cycle(0, 8'h00, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
